// File: rtl/vec_mem_pkg.sv
// Shared types and constants for the vector memory stage.
package vec_mem_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LANES      = 16;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned VEC_W      = LANES * LANE_W;
  localparam int unsigned BEATS      = VEC_W / WORD_W;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BEAT_IDX_W = $clog2(BEATS);

  // Low address bits that must be zero for a 16-byte aligned vector access.
  localparam logic [3:0] VEC_ALIGN_MASK = 4'hF;

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StWait,
    StDone
  } vec_state_e;

  // Byte address of beat idx; each beat is one 4-byte word, wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0]     base,
                                                  input logic [BEAT_IDX_W-1:0] idx);
    return base + ADDR_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/vec_mem_stage_if.sv
// Pipeline-side request/response and data-RAM port of the vector memory stage.
interface vec_mem_stage_if;
  import vec_mem_pkg::*;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [VEC_W-1:0]  data_b_i;
  logic              stall_o;
  logic [VEC_W-1:0]  q_b_o;
  logic              done_o;
  logic              align_err_o;
  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [WORD_W-1:0] ram_wd_o;
  logic [WORD_W-1:0] ram_rd_i;

  // Pipeline and RAM environment.
  modport master (
    output mem_req_i, mem_we_i, addr_i, data_b_i, ram_rd_i,
    input  stall_o, q_b_o, done_o, align_err_o, ram_en_o, ram_we_o, ram_addr_o, ram_wd_o
  );

  // The memory stage itself.
  modport slave (
    input  mem_req_i, mem_we_i, addr_i, data_b_i, ram_rd_i,
    output stall_o, q_b_o, done_o, align_err_o, ram_en_o, ram_we_o, ram_addr_o, ram_wd_o
  );

endinterface

// File: rtl/vec_beat_pack.sv
// Beat slicing of the store vector and assembly of read beats into the load result.
module vec_beat_pack
  import vec_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VEC_W-1:0]      vec,
  input  logic [BEAT_IDX_W-1:0] sel,
  output logic [WORD_W-1:0]     beat,
  input  logic                  cap_en,
  input  logic [BEAT_IDX_W-1:0] cap_idx,
  input  logic [WORD_W-1:0]     cap_data,
  input  logic                  commit,
  output logic [VEC_W-1:0]      q
);

  logic [BEATS-1:0][WORD_W-1:0] vec_beats;
  logic [BEATS-1:0][WORD_W-1:0] asm_q;
  logic [BEATS-1:0][WORD_W-1:0] merged;
  logic [BEATS-1:0][WORD_W-1:0] q_q;

  assign vec_beats = vec;
  assign q         = q_q;

  // Select the store word for the current beat.
  always_comb begin
    beat = vec_beats[sel];
  end

  // Overlay the incoming read word onto the partially assembled vector.
  always_comb begin
    merged          = asm_q;
    merged[cap_idx] = cap_data;
  end

  // Assemble beats privately; the visible result only changes when the last beat commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q <= '0;
      q_q   <= '0;
    end else if (cap_en) begin
      asm_q <= merged;
      if (commit) begin
        q_q <= merged;
      end
    end
  end

endmodule

// File: rtl/vec_mem_stage.sv
// Vector memory stage: moves a 128-bit vector as four 32-bit beats over one RAM port.
module vec_mem_stage
  import vec_mem_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  vec_mem_stage_if.slave  bus
);

  vec_state_e              state_q, state_d;
  logic [BEAT_IDX_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic                    we_q, we_d;
  logic [VEC_W-1:0]        data_q, data_d;
  logic                    err_q, err_d;

  logic                    stall;
  logic                    done;
  logic                    align_err;
  logic                    ram_en;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [WORD_W-1:0]       ram_wd;
  logic                    cap_en;
  logic [BEAT_IDX_W-1:0]   cap_idx;
  logic                    commit;
  logic [WORD_W-1:0]       beat_wd;
  logic [VEC_W-1:0]        q_b;

  vec_beat_pack u_pack (
    .clk      (clk),
    .reset    (reset),
    .vec      (data_q),
    .sel      (beat_q),
    .beat     (beat_wd),
    .cap_en   (cap_en),
    .cap_idx  (cap_idx),
    .cap_data (bus.ram_rd_i),
    .commit   (commit),
    .q        (q_b)
  );

  // Next-state and output decode; outputs default to idle values.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    we_d      = we_q;
    data_d    = data_q;
    err_d     = err_q;
    stall     = 1'b0;
    done      = 1'b0;
    align_err = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wd    = '0;
    cap_en    = 1'b0;
    cap_idx   = '0;
    commit    = 1'b0;

    unique case (state_q)
      StIdle: begin
        stall = bus.mem_req_i;
        if (bus.mem_req_i) begin
          base_d = bus.addr_i;
          we_d   = bus.mem_we_i;
          data_d = bus.data_b_i;
          beat_d = '0;
          if ((bus.addr_i[3:0] & VEC_ALIGN_MASK) == 4'h0) begin
            err_d   = 1'b0;
            state_d = StXfer;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end

      StXfer: begin
        stall    = 1'b1;
        ram_en   = 1'b1;
        ram_we   = we_q;
        ram_addr = beat_addr(base_q, beat_q);
        if (we_q) begin
          ram_wd = beat_wd;
        end
        // Read data trails its issue by one cycle, so capture the previous beat.
        if (!we_q && (beat_q != '0)) begin
          cap_en  = 1'b1;
          cap_idx = beat_q - BEAT_IDX_W'(1);
        end
        if (beat_q == LAST_BEAT) begin
          state_d = we_q ? StDone : StWait;
        end else begin
          beat_d = beat_q + BEAT_IDX_W'(1);
        end
      end

      StWait: begin
        stall   = 1'b1;
        cap_en  = 1'b1;
        cap_idx = LAST_BEAT;
        commit  = 1'b1;
        state_d = StDone;
      end

      StDone: begin
        // The request still presented here is the instruction just completed.
        done      = 1'b1;
        align_err = err_q;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and captured request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      we_q    <= we_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.done_o      = done;
  assign bus.align_err_o = align_err;
  // A reset cycle never issues a RAM access, so an aborted store stops at once.
  assign bus.ram_en_o    = ram_en & ~reset;
  assign bus.ram_we_o    = ram_we & ~reset;
  assign bus.ram_addr_o  = ram_addr;
  assign bus.ram_wd_o    = ram_wd;
  assign bus.q_b_o       = q_b;

endmodule

// File: tb/tb_vec_mem_stage.sv
// Directed self-checking bench for vec_mem_stage with a behavioural data RAM.
module tb_vec_mem_stage;
  import vec_mem_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  vec_mem_stage_if bus ();

  vec_mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [127:0] D1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] D2 = 128'hDDCCBBAA_99887766_55443322_11FFEE00;
  localparam logic [127:0] D3 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] D4 = 128'hFC00FC00_F800F800_F400F400_F000F000;

  // Behavioural RAM: one-cycle read latency.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      if (bus.ram_we_o) mem[bus.ram_addr_o] = bus.ram_wd_o;
      else if (mem.exists(bus.ram_addr_o)) rd_q <= mem[bus.ram_addr_o];
      else rd_q <= 32'hDEADBEEF;
    end
  end

  assign bus.ram_rd_i = rd_q;

  // {ram_en, ram_we, stall, done, align_err}
  function automatic logic [4:0] ctl5();
    return {bus.ram_en_o, bus.ram_we_o, bus.stall_o, bus.done_o, bus.align_err_o};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEADBEEF;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic en, input logic we, input logic [31:0] a,
                     input logic [127:0] d);
    bus.mem_req_i = en;
    bus.mem_we_i  = we;
    bus.addr_i    = a;
    bus.data_b_i  = d;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req(1'b0, 1'b0, 32'h0, 128'h0);
    step();
    step();
    checks++; if (ctl5() !== 5'b00000) begin failures++;
      $display("FAIL reset_ctl got=%b exp=00000", ctl5()); end
    checks++; if ({bus.ram_addr_o, bus.ram_wd_o, bus.q_b_o} !== 192'h0) begin failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", bus.ram_addr_o, bus.ram_wd_o, bus.q_b_o); end
    reset = 1'b0;
    step();
    checks++; if (ctl5() !== 5'b00000) begin failures++;
      $display("FAIL reset_idle got=%b exp=00000", ctl5()); end
  endtask

  task automatic test_store();
    logic [127:0] dv;
    dv = D1;
    req(1'b1, 1'b1, 32'h100, dv);
    checks++; if (ctl5() !== 5'b00100) begin failures++;
      $display("FAIL store_accept got=%b exp=00100", ctl5()); end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (ctl5() !== 5'b11100) begin failures++;
        $display("FAIL store_beat%0d_ctl got=%b exp=11100", k, ctl5()); end
      checks++; if ({bus.ram_addr_o, bus.ram_wd_o} !== {32'h100 + 32'(4 * k), dv[32*k +: 32]})
        begin failures++;
        $display("FAIL store_beat%0d_bus got=%h:%h exp=%h:%h", k, bus.ram_addr_o,
                 bus.ram_wd_o, 32'h100 + 32'(4 * k), dv[32*k +: 32]); end
      step();
    end
    checks++; if (ctl5() !== 5'b00010) begin failures++;
      $display("FAIL store_done got=%b exp=00010", ctl5()); end
    checks++; if (bus.q_b_o !== 128'h0) begin failures++;
      $display("FAIL store_q_unchanged got=%h exp=0", bus.q_b_o); end
    req(1'b0, 1'b0, 32'h0, 128'h0);
    step();
    checks++; if (ctl5() !== 5'b00000) begin failures++;
      $display("FAIL store_idle got=%b exp=00000", ctl5()); end
    checks++; if ({mem_rd(32'h10C), mem_rd(32'h108), mem_rd(32'h104), mem_rd(32'h100)} !== D1)
      begin failures++;
      $display("FAIL store_mem got=%h%h%h%h exp=%h", mem_rd(32'h10C), mem_rd(32'h108),
               mem_rd(32'h104), mem_rd(32'h100), D1); end
  endtask

  task automatic test_load();
    req(1'b1, 1'b0, 32'h100, '1);
    checks++; if (ctl5() !== 5'b00100) begin failures++;
      $display("FAIL load_accept got=%b exp=00100", ctl5()); end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if ({ctl5(), bus.ram_addr_o} !== {5'b10100, 32'h100 + 32'(4 * k)}) begin
        failures++;
        $display("FAIL load_beat%0d got=%b:%h exp=10100:%h", k, ctl5(), bus.ram_addr_o,
                 32'h100 + 32'(4 * k)); end
      step();
    end
    checks++; if ({ctl5(), bus.q_b_o} !== {5'b00100, 128'h0}) begin failures++;
      $display("FAIL load_wait got=%b:%h exp=00100:0", ctl5(), bus.q_b_o); end
    step();
    checks++; if ({ctl5(), bus.q_b_o} !== {5'b00010, D1}) begin failures++;
      $display("FAIL load_done got=%b:%h exp=00010:%h", ctl5(), bus.q_b_o, D1); end
    req(1'b0, 1'b0, 32'h0, 128'h0);
    step();
    checks++; if ({ctl5(), bus.q_b_o} !== {5'b00000, D1}) begin failures++;
      $display("FAIL load_hold got=%b:%h exp=00000:%h", ctl5(), bus.q_b_o, D1); end
  endtask

  task automatic test_misaligned();
    req(1'b1, 1'b1, 32'h102, D2);
    checks++; if (ctl5() !== 5'b00100) begin failures++;
      $display("FAIL misal_accept got=%b exp=00100", ctl5()); end
    step();
    checks++; if ({ctl5(), bus.q_b_o} !== {5'b00011, D1}) begin failures++;
      $display("FAIL misal_done got=%b:%h exp=00011:%h", ctl5(), bus.q_b_o, D1); end
    req(1'b0, 1'b0, 32'h0, 128'h0);
    step();
    checks++; if ({ctl5(), bus.q_b_o} !== {5'b00000, D1}) begin failures++;
      $display("FAIL misal_after got=%b:%h exp=00000:%h", ctl5(), bus.q_b_o, D1); end
    checks++; if ({mem_rd(32'h100), mem_rd(32'h102)} !== {32'h03020100, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL misal_mem got=%h:%h exp=03020100:deadbeef", mem_rd(32'h100),
               mem_rd(32'h102)); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] dv;
    dv = D2;
    req(1'b1, 1'b1, 32'h200, dv);
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if ({ctl5(), bus.ram_addr_o, bus.ram_wd_o} !==
                    {5'b11100, 32'h200 + 32'(4 * k), dv[32*k +: 32]}) begin failures++;
        $display("FAIL b2b_wr%0d got=%b:%h:%h exp=11100:%h:%h", k, ctl5(), bus.ram_addr_o,
                 bus.ram_wd_o, 32'h200 + 32'(4 * k), dv[32*k +: 32]); end
      step();
    end
    // Store still presented during DONE; it must not be re-issued.
    checks++; if (ctl5() !== 5'b00010) begin failures++;
      $display("FAIL b2b_store_done got=%b exp=00010", ctl5()); end
    step();
    req(1'b1, 1'b0, 32'h200, 128'h0);
    checks++; if (ctl5() !== 5'b00100) begin failures++;
      $display("FAIL b2b_load_accept got=%b exp=00100", ctl5()); end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if ({ctl5(), bus.ram_addr_o} !== {5'b10100, 32'h200 + 32'(4 * k)}) begin
        failures++;
        $display("FAIL b2b_rd%0d got=%b:%h exp=10100:%h", k, ctl5(), bus.ram_addr_o,
                 32'h200 + 32'(4 * k)); end
      step();
    end
    step();
    checks++; if ({ctl5(), bus.q_b_o} !== {5'b00010, D2}) begin failures++;
      $display("FAIL b2b_load_done got=%b:%h exp=00010:%h", ctl5(), bus.q_b_o, D2); end
    req(1'b0, 1'b0, 32'h0, 128'h0);
    step();
  endtask

  task automatic test_reset_mid();
    req(1'b1, 1'b1, 32'h100, D3);
    step();
    step();
    step();
    // Cycle T+3: reset arrives and the pipeline withdraws the request.
    reset = 1'b1;
    req(1'b0, 1'b0, 32'h0, 128'h0);
    step();
    reset = 1'b0;
    #1;
    checks++; if ({ctl5(), bus.q_b_o} !== {5'b00000, 128'h0}) begin failures++;
      $display("FAIL rstmid_after got=%b:%h exp=00000:0", ctl5(), bus.q_b_o); end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (ctl5() !== 5'b00000) begin failures++;
        $display("FAIL rstmid_quiet%0d got=%b exp=00000", c, ctl5()); end
    end
    checks++; if ({mem_rd(32'h10C), mem_rd(32'h108), mem_rd(32'h104), mem_rd(32'h100)} !==
                  128'h0F0E0D0C_0B0A0908_A1A1A1A1_A0A0A0A0) begin failures++;
      $display("FAIL rstmid_mem got=%h%h%h%h exp=0f0e0d0c0b0a0908a1a1a1a1a0a0a0a0",
               mem_rd(32'h10C), mem_rd(32'h108), mem_rd(32'h104), mem_rd(32'h100)); end
  endtask

  task automatic test_wrap();
    logic [127:0] dv;
    logic [31:0]  a;
    dv = D4;
    req(1'b1, 1'b1, 32'hFFFFFFF0, dv);
    step();
    for (int k = 0; k < 4; k++) begin
      a = 32'hFFFFFFF0 + 32'(4 * k);
      checks++; if ({ctl5(), bus.ram_addr_o, bus.ram_wd_o} !== {5'b11100, a, dv[32*k +: 32]})
        begin failures++;
        $display("FAIL wrap_wr%0d got=%b:%h:%h exp=11100:%h:%h", k, ctl5(), bus.ram_addr_o,
                 bus.ram_wd_o, a, dv[32*k +: 32]); end
      step();
    end
    req(1'b0, 1'b0, 32'h0, 128'h0);
    step();
    req(1'b1, 1'b0, 32'hFFFFFFF0, 128'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      a = 32'hFFFFFFF0 + 32'(4 * k);
      checks++; if ({ctl5(), bus.ram_addr_o} !== {5'b10100, a}) begin failures++;
        $display("FAIL wrap_rd%0d got=%b:%h exp=10100:%h", k, ctl5(), bus.ram_addr_o, a); end
      step();
    end
    step();
    checks++; if ({ctl5(), bus.q_b_o} !== {5'b00010, D4}) begin failures++;
      $display("FAIL wrap_done got=%b:%h exp=00010:%h", ctl5(), bus.q_b_o, D4); end
    checks++; if (mem.exists(32'h0) !== 1'b0) begin failures++;
      $display("FAIL wrap_no_zero got=%b exp=0", mem.exists(32'h0)); end
    req(1'b0, 1'b0, 32'h0, 128'h0);
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.mem_req_i = 1'b0;
    bus.mem_we_i  = 1'b0;
    bus.addr_i    = '0;
    bus.data_b_i  = '0;
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
